booth_mult: RTL and testbench
=============================

# booth_mult

Iterative 32x32 signed multiplier for the datapath's `mult` instruction. It is the counterpart of the sequential divider: it consumes the same operand pair under a held control line from the control unit and returns a 64-bit product split into HI/LO. It uses radix-2 Booth recoding, one iteration per clock, over 32 iterations. Results stay registered until the next multiply completes, so the HI/LO move instructions can read them at any later time.

## Interface
- No parameters. Widths are fixed at 32-bit operands and a 64-bit product.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `multOp` input 1: control-unit request. It is held high for the whole operation.
- `multiplicand` input 32: operand A, two's complement. Sampled only on the start edge.
- `multiplier` input 32: operand B, two's complement. Sampled only on the start edge.
- `mult_hi` output 32: product bits [63:32].
- `mult_lo` output 32: product bits [31:0].
- `mult_busy` output 1: high while iterating.
- `mult_done` output 1: one-cycle pulse when `mult_hi`/`mult_lo` update.

## Operation
- **Reset** (async, any state):
  - State goes to IDLE.
  - `mult_hi`, `mult_lo`, `mult_busy`, `mult_done` and the counter all go to 0.
- **FSM states:** IDLE, BUSY, DONE, WAIT.
- **IDLE:**
  - With `multOp`=1 at a clock edge, load `M` = sign-extended A (33 bits).
  - Load `P` = {33'b0, B, 1'b0} (66 bits) and set counter = 0.
  - Go to BUSY.
- **BUSY, each edge:**
  - Examine `P[1:0]`:
    - 01: `P[65:33]` += `M`.
    - 10: `P[65:33]` -= `M`.
    - 00 or 11: no add.
  - Then arithmetic-shift `P` right by 1, replicating bit 65.
  - Increment the counter.
- **Accumulator width:** the 33-bit accumulator is required so that subtracting `M`=-2^31 does not overflow.
- **32nd iteration edge** (counter = 31 before the edge):
  - Write `mult_hi` = `P'[64:33]` and `mult_lo` = `P'[32:1]`, where `P'` is the shifted value.
  - Go to DONE.
- **DONE** lasts exactly one cycle, with `mult_done`=1. Next state:
  - WAIT if `multOp`=1.
  - IDLE if `multOp`=0.
- **WAIT:** stay while `multOp`=1 and go to IDLE when it is 0. A held request therefore never restarts the multiplier.
- **Abort:** `multOp`=0 sampled in BUSY returns to IDLE.
  - `mult_hi`/`mult_lo` keep their previous values.
  - `mult_done` is not asserted.
- **Operand changes:** changes on `multiplicand`/`multiplier` after the start edge have no effect.
- **Output holding:** outputs change only on reset or on the 32nd-iteration edge. All outputs are registered; no combinational path runs from inputs to outputs.
- **Arithmetic:** the product is full signed 64-bit and exact for all operand pairs, with no overflow flag.

## Timing
- **Start edge E0:** IDLE samples `multOp`=1. `mult_busy`=1 from E0 until E32.
- **Iterations:** edges E1..E32, one per edge.
- **Result edge E32:**
  - `mult_hi`/`mult_lo` update.
  - `mult_busy` goes to 0.
  - `mult_done` goes to 1.
- **E33:** `mult_done` goes to 0.
- **Latency:** 32 cycles from the start edge to valid outputs. The earliest next start is E34 if `multOp` drops before E33; otherwise it follows the first edge at which WAIT samples `multOp`=0.
- **Simultaneous events:**
  - Reset asserted with any edge wins.
  - `multOp` falling exactly at E32 still completes. The result is written, `mult_done` pulses, and DONE then goes to IDLE.

## Test plan
- **3 x 5:** `multOp`=1 held → at E32 `mult_hi`=0x00000000, `mult_lo`=0x0000000F. `mult_done` high for one cycle only; no restart while `multOp` stays high for 10 more cycles.
- **-7 x 6** (0xFFFFFFF9, 0x00000006) → `mult_hi`=0xFFFFFFFF, `mult_lo`=0xFFFFFFD6.
- **Extremes:**
  - 0x80000000 x 0x80000000 → `mult_hi`=0x40000000, `mult_lo`=0x00000000.
  - 0xFFFFFFFF x 0xFFFFFFFF → `mult_hi`=0, `mult_lo`=1.
  - 0x7FFFFFFF x 0x80000000 → `mult_hi`=0xC0000000, `mult_lo`=0x80000000.
- **Abort:**
  - Complete 3 x 5.
  - Start 0x1234 x 0x10 and drop `multOp` after E10 → no `mult_done`, outputs remain 0/0x0F, `mult_busy`=0.
  - Restart 0x1234 x 0x10 → `mult_lo`=0x00012340 at E32 of the new run.
- **Reset:**
  - Assert `reset` asynchronously mid-cycle at iteration 16 → all outputs 0 immediately (before the next edge), state IDLE.
  - After release, 2 x -1 → `mult_hi`=0xFFFFFFFF, `mult_lo`=0xFFFFFFFE.
- **Random:** 1000 random signed pairs, each with operand inputs scrambled after E0 → every product matches the 64-bit signed reference at E32, and latency is exactly 32.

Source files
------------

// File: rtl/booth_mult.sv
// Iterative 32x32 signed radix-2 Booth multiplier: one iteration per clock.
// Latency 32 cycles from the start edge to the HI/LO update. A held request completes only once.
// Dropping the request mid-run aborts it. Results persist until the next multiply completes.
module booth_mult (
    input  logic        clk,
    input  logic        reset,
    input  logic        multOp,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic [31:0] mult_hi,
    output logic [31:0] mult_lo,
    output logic        mult_busy,
    output logic        mult_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [32:0] m_q, m_d;
    logic [65:0] p_q, p_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [32:0] acc;
    logic [65:0] p_step;

    // 33-bit accumulator keeps subtracting M = -2^31 from overflowing.
    always_comb begin
        acc = p_q[65:33];
        case (p_q[1:0])
            2'b01:   acc = p_q[65:33] + m_q;
            2'b10:   acc = p_q[65:33] - m_q;
            default: acc = p_q[65:33];
        endcase
        p_step = {acc[32], acc, p_q[32:1]};
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (multOp) begin
                    m_d     = {multiplicand[31], multiplicand};
                    p_d     = {33'b0, multiplier, 1'b0};
                    cnt_d   = 5'd0;
                    busy_d  = 1'b1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // The final iteration completes even if the request drops on that edge.
                if (cnt_q == 5'd31) begin
                    p_d     = p_step;
                    cnt_d   = cnt_q + 5'd1;
                    hi_d    = p_step[64:33];
                    lo_d    = p_step[32:1];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (!multOp) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    p_d   = p_step;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_DONE: begin
                state_d = multOp ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (!multOp) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mult_hi   = hi_q;
    assign mult_lo   = lo_q;
    assign mult_busy = busy_q;
    assign mult_done = done_q;

endmodule

// File: tb/tb_booth_mult.sv
// Directed and random checks of booth_mult against hand-computed and 64-bit signed reference products.
module tb_booth_mult;

    logic        clk;
    logic        reset;
    logic        multOp;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic        mult_busy;
    logic        mult_done;

    int tests;
    int fails;

    booth_mult dut (
        .clk          (clk),
        .reset        (reset),
        .multOp       (multOp),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .mult_hi      (mult_hi),
        .mult_lo      (mult_lo),
        .mult_busy    (mult_busy),
        .mult_done    (mult_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          hold;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One full multiply; operands are scrambled after the start edge.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input int hold,
                            output logic [31:0] hi, output logic [31:0] lo,
                            output int lat, output int extra);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        multOp       = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (lat < 40 && !mult_done) begin
            @(negedge clk);
            multiplicand = $urandom;
            multiplier   = $urandom;
            @(posedge clk);
            #1;
            lat++;
        end
        hi = mult_hi;
        lo = mult_lo;
        extra = 0;
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (mult_done || mult_busy) extra++;
        end
        @(negedge clk);
        multOp = 1'b0;
        @(posedge clk);
    endtask

    vec_t        vecs[10];
    logic [31:0] hi, lo;
    int          lat, extra, seen_done;
    logic signed [63:0] sa, sb, ref_p;

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        multOp = 1'b0;
        multiplicand = '0;
        multiplier = '0;

        vecs[0] = '{32'd3,        32'd5,        32'h00000000, 32'h0000000F, 10};
        vecs[1] = '{32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6, 0};
        vecs[2] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0};
        vecs[4] = '{32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 0};
        vecs[5] = '{32'h00001234, 32'h00000010, 32'h00000000, 32'h00012340, 0};
        vecs[6] = '{32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 0};
        vecs[7] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0};
        vecs[8] = '{32'h000186A0, 32'h000186A0, 32'h00000002, 32'h540BE400, 0};
        vecs[9] = '{32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3};

        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", 64'(mult_hi), 64'h0);
        check("reset_lo", 64'(mult_lo), 64'h0);
        check("reset_busy", 64'(mult_busy), 64'h0);
        check("reset_done", 64'(mult_done), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_mult(vecs[i].a, vecs[i].b, vecs[i].hold, hi, lo, lat, extra);
            check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
            check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
            if (vecs[i].hold > 0)
                check($sformatf("vec%0d_no_restart", i), 64'(extra), 64'd0);
        end

        // Abort after E10 must leave the previous 3 x 5 result untouched.
        run_mult(32'd3, 32'd5, 0, hi, lo, lat, extra);
        seen_done = 0;
        @(negedge clk);
        multiplicand = 32'h1234;
        multiplier   = 32'h10;
        multOp       = 1'b1;
        @(posedge clk);
        repeat (10) begin
            @(posedge clk);
            #1;
            if (mult_done) seen_done++;
        end
        @(negedge clk);
        multOp = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (mult_done) seen_done++;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        check("abort_busy", 64'(mult_busy), 64'd0);
        check("abort_hi", 64'(mult_hi), 64'h0);
        check("abort_lo", 64'(mult_lo), 64'hF);
        run_mult(32'h1234, 32'h10, 0, hi, lo, lat, extra);
        check("restart_lo", 64'(lo), 64'h00012340);
        check("restart_hi", 64'(hi), 64'h0);
        check("restart_latency", 64'(lat), 64'd32);

        // Asynchronous reset in the middle of iteration 16.
        @(negedge clk);
        multiplicand = 32'h55;
        multiplier   = 32'h3;
        multOp       = 1'b1;
        @(posedge clk);
        repeat (16) @(posedge clk);
        #1;
        check("pre_reset_busy", 64'(mult_busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_hi", 64'(mult_hi), 64'h0);
        check("midreset_lo", 64'(mult_lo), 64'h0);
        check("midreset_busy", 64'(mult_busy), 64'h0);
        check("midreset_done", 64'(mult_done), 64'h0);
        @(negedge clk);
        multOp = 1'b0;
        reset  = 1'b0;
        run_mult(32'd2, 32'hFFFFFFFF, 0, hi, lo, lat, extra);
        check("post_reset_hi", 64'(hi), 64'hFFFFFFFF);
        check("post_reset_lo", 64'(lo), 64'hFFFFFFFE);

        // Request falls exactly at E32: still completes, then an immediate restart at E34.
        @(negedge clk);
        multiplicand = 32'd6;
        multiplier   = 32'd7;
        multOp       = 1'b1;
        @(posedge clk);
        repeat (31) @(posedge clk);
        @(negedge clk);
        multOp = 1'b0;
        @(posedge clk);
        #1;
        check("e32fall_done", 64'(mult_done), 64'd1);
        check("e32fall_lo", 64'(mult_lo), 64'd42);
        check("e32fall_hi", 64'(mult_hi), 64'd0);
        @(posedge clk);
        #1;
        check("e33_done_low", 64'(mult_done), 64'd0);
        check("e33_busy_low", 64'(mult_busy), 64'd0);
        run_mult(32'hFFFFFFFD, 32'hFFFFFFFC, 0, hi, lo, lat, extra);
        check("e34_start_lo", 64'(lo), 64'd12);
        check("e34_start_hi", 64'(hi), 64'd0);
        check("e34_start_latency", 64'(lat), 64'd32);

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            sa = $signed(ra);
            sb = $signed(rb);
            ref_p = sa * sb;
            run_mult(ra, rb, 0, hi, lo, lat, extra);
            check($sformatf("rand%0d_product", i), {hi, lo}, ref_p);
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'd32);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
